reg_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 32×64 register file among several result producers, e.g. ALU, load unit and multiplier. It accepts at most one write request per cycle through a valid/ready handshake. The winner is registered and driven to the register-file write port as a one-cycle `wr_en` pulse with stable address and data. It sits between the execution units and the register file and is the only driver of the register-file write port.

---
 rtl/reg_wr_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/reg_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_reg_wr_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wr_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Optional feature macro: REG_WR_ARB_DROP_X0_EN (register 0 hard-wired to zero).
package reg_wr_arb_pkg;

    // Default configuration: 3 producers sharing a 32 x 64 register file.
    localparam int RWA_NUM_REQ = 3;
    localparam int RWA_ADDR_W  = 5;
    localparam int RWA_DATA_W  = 64;

    // Requester slot assignment on the req_* buses.
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MUL  = 2;

    // Grant index / round-robin pointer; 3 bits covers up to 8 requesters.
    localparam int GRANT_W = 3;
    typedef logic [GRANT_W-1:0] grant_t;

endpackage : reg_wr_arb_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// scanning upward and wrapping to 0. ptr is assumed to be < NUM_REQ.
module rr_arbiter
    import reg_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = RWA_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  grant_t             ptr,
    output logic [NUM_REQ-1:0] gnt,
    output grant_t             gnt_idx,
    output logic               gnt_valid
);

    // Two passes: first the upper segment [ptr, NUM_REQ-1], then the wrap to [0, ptr-1].
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_valid && req[i] && (i >= int'(ptr))) begin
                gnt[i]    = 1'b1;
                gnt_idx   = grant_t'(i);
                gnt_valid = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_valid && req[i]) begin
                gnt[i]    = 1'b1;
                gnt_idx   = grant_t'(i);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter owning the single register-file write port.
// Optional feature macro: REG_WR_ARB_DROP_X0_EN -- writes to register 0 are
// acknowledged but never reach the write port (hard-wired-zero x0).
//
// Handshake: requester i's write is accepted in a cycle where req_valid[i]
// and req_ready[i] are both high; the requester holds addr/data stable until
// then and may withdraw by dropping req_valid. req_ready is at most one-hot
// and is all-zero while stall is high or rst_n is low.
module reg_wr_arbiter
    import reg_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = RWA_NUM_REQ,
    parameter int ADDR_W  = RWA_ADDR_W,
    parameter int DATA_W  = RWA_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [GRANT_W-1:0]        grant_id,
    output logic [31:0]               wr_count
);

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] gnt;
    grant_t             gnt_idx;
    logic               hs;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               drop_wr;

    grant_t             rr_ptr_q, rr_ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    grant_t             grant_id_q, grant_id_d;
    logic [31:0]        wr_count_q, wr_count_d;

    // No candidates while stalled or held in reset.
    assign cand = req_valid & {NUM_REQ{rst_n & ~stall}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (cand),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (hs)
    );

    assign req_ready = gnt;

    // One-hot mux of the winner's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REG_WR_ARB_DROP_X0_EN
    assign drop_wr = (sel_addr == '0);
`else
    assign drop_wr = 1'b0;
`endif

    // Next state: capture the winner on a handshake, otherwise hold and idle the port.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        wr_count_d = wr_count_q;
        if (hs) begin
            rr_ptr_d   = (gnt_idx == grant_t'(NUM_REQ - 1)) ? '0 : gnt_idx + grant_t'(1);
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
            grant_id_d = gnt_idx;
            if (!drop_wr) begin
                wr_en_d    = 1'b1;
                wr_count_d = wr_count_q + 32'd1;
            end
        end
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
            wr_count_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;
    assign wr_count = wr_count_q;

endmodule : reg_wr_arbiter

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter with hand-computed expectations.
// Build with REG_WR_ARB_DROP_X0_EN defined to exercise the x0-drop behaviour.
module tb_reg_wr_arbiter;
    import reg_wr_arb_pkg::*;

    localparam int NR = RWA_NUM_REQ;
    localparam int AW = RWA_ADDR_W;
    localparam int DW = RWA_DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               stall;
    logic [NR-1:0]      req_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [2:0]         grant_id;
    logic [31:0]        wr_count;

    logic [AW-1:0]      addr_a [NR];
    logic [DW-1:0]      data_a [NR];

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = addr_a[i];
            req_data[i*DW +: DW] = data_a[i];
        end
    end

    reg_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .wr_count  (wr_count)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr_a[i] = a;
        data_a[i] = d;
    endtask

    task automatic check_write(input string tag, input logic [2:0] g,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_count++;
        check({tag, "_wr_en"}, 64'(wr_en), 64'd1);
        check({tag, "_grant"}, 64'(grant_id), 64'(g));
        check({tag, "_addr"}, 64'(wr_addr), 64'(a));
        check({tag, "_data"}, 64'(wr_data), d);
        check({tag, "_count"}, 64'(wr_count), 64'(exp_count));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        stall     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) set_req(i, '0, '0);

        // Reset: every output at its reset value; ready stays low even with valid requests.
        tick();
        tick();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        req_valid = 3'b111;
        #1;
        check("rst_ready_gated", 64'(req_ready), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();
        check("idle_ready", 64'(req_ready), 64'd0);
        check("idle_wr_en", 64'(wr_en), 64'd0);

        // Single request from requester 1.
        set_req(REQ_LOAD, 5'd7, 64'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        check("single_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        check_write("single", 3'd1, 5'd7, 64'hDEAD_BEEF);
        tick();
        check("single_wr_en_drop", 64'(wr_en), 64'd0);
        check("single_addr_hold", 64'(wr_addr), 64'd7);
        check("single_grant_hold", 64'(grant_id), 64'd1);
        check("single_count_hold", 64'(wr_count), 64'd1);

        // Contention from reset: all three valid for 6 cycles -> 0,1,2,0,1,2.
        rst_n = 1'b0;
        exp_count = 0;
        for (int i = 0; i < NR; i++) set_req(i, AW'(10 + i), DW'(64'h100 + i));
        req_valid = 3'b111;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % NR;
            #1;
            check("cont_ready", 64'(req_ready), 64'(1 << g));
            tick();
            check_write("cont", 3'(g), AW'(10 + g), DW'(64'h100 + g));
        end
        req_valid = '0;
        tick();
        check("cont_idle_wr_en", 64'(wr_en), 64'd0);
        check("cont_final_count", 64'(wr_count), 64'd6);

        // Stall for 3 cycles with requesters 0 and 2 valid (pointer is back at 0).
        stall     = 1'b1;
        req_valid = 3'b101;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ready", 64'(req_ready), 64'd0);
            tick();
            check("stall_wr_en", 64'(wr_en), 64'd0);
        end
        stall = 1'b0;
        #1;
        check("unstall_ready0", 64'(req_ready), 64'b001);
        tick();
        check_write("unstall_first", 3'd0, 5'd10, 64'h100);
        check("unstall_ready2", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        check_write("unstall_second", 3'd2, 5'd12, 64'h102);

        // Reset mid-write: pointer is 1 with requester 2 pending; reset wipes it.
        req_valid = 3'b001;
        #1;
        check("midrst_ready0", 64'(req_ready), 64'b001);
        tick();
        check_write("midrst_pre", 3'd0, 5'd10, 64'h100);
        req_valid = 3'b101;
        #1;
        check("midrst_ready_ptr1", 64'(req_ready), 64'b100);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en_cleared", 64'(wr_en), 64'd0);
        check("midrst_ready_low", 64'(req_ready), 64'd0);
        check("midrst_count_cleared", 64'(wr_count), 64'd0);
        exp_count = 0;
        tick();
        rst_n = 1'b1;
        #1;
        check("midrst_ready_lowest", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        check_write("midrst_post", 3'd0, 5'd10, 64'h100);
        tick();

        // Address-0 write from requester 0, then address 3 from requester 1.
        set_req(REQ_ALU, 5'd0, 64'h55);
        set_req(REQ_LOAD, 5'd3, 64'h33);
        req_valid = 3'b001;
        #1;
        check("x0_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b010;
`ifdef REG_WR_ARB_DROP_X0_EN
        check("x0_dropped_wr_en", 64'(wr_en), 64'd0);
        check("x0_dropped_count", 64'(wr_count), 64'(exp_count));
`else
        check_write("x0_written", 3'd0, 5'd0, 64'h55);
`endif
        #1;
        check("x3_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        check_write("x3", 3'd1, 5'd3, 64'h33);
        tick();
        check("final_idle_wr_en", 64'(wr_en), 64'd0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_wr_arbiter
